// File: rtl/ysyx_24100005_pkg.sv
// Shared constants for the ysyx_24100005 register-file write path and its arbiters.
package ysyx_24100005_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_ZERO   = 0;

  // A one-requester arbiter still needs a 1-bit pointer so port widths stay legal.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_24100005_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping to 0.
module ysyx_24100005_rr_pick
  import ysyx_24100005_pkg::*;
#(
  parameter  int N  = 3,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic          hi_found;
  logic          lo_found;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Scanning downward lets the last hit win, leaving the lowest index in each half.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(k);
        if (k >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(k);
        end
      end
    end
  end

  assign any = lo_found;
  assign idx = hi_found ? hi_idx : lo_idx;
  assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/ysyx_24100005_rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with a one-cycle
// registered write stage, x0 filtering and a bypass compare for the pending write.
module ysyx_24100005_rf_wr_arbiter
  import ysyx_24100005_pkg::*;
#(
  parameter int NR_REQ     = 3,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  input  logic [ADDR_WIDTH-1:0]        byp_raddr,
  output logic                         byp_hit,
  output logic [DATA_WIDTH-1:0]        byp_data
);

  localparam int PW = ptr_w(NR_REQ);

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [NR_REQ-1:0]     pick_req;
  logic [NR_REQ-1:0]     pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Masking the requests (not the grant) keeps ready all-zero during reset and hold.
  assign pick_req = (rst || hold) ? '0 : req_valid;

  ysyx_24100005_rr_pick #(.N(NR_REQ)) u_pick (
    .req (pick_req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_ready = pick_gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rr_ptr_d   = rr_ptr_q;
    if (pick_any) begin
      // Writes to x0 complete the handshake but never reach the register file.
      rf_wen_d   = (sel_addr != ADDR_WIDTH'(REG_ZERO));
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
      rr_ptr_d   = (pick_idx == PW'(NR_REQ - 1)) ? '0 : pick_idx + PW'(1);
    end
  end

  // Write-port register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  assign byp_hit  = rf_wen_q && (byp_raddr == rf_waddr_q) &&
                    (byp_raddr != ADDR_WIDTH'(REG_ZERO));
  assign byp_data = byp_hit ? rf_wdata_q : '0;

endmodule
